// File: rtl/hdmi_mode_switcher.sv
// hdmi_mode_switcher: selects one of NUM_MODES pre-encoded TMDS symbol sets
// (plus its cx/cy counters) for the serializer. Mode changes are debounced,
// aligned to the active mode's frame origin and followed by a run of TMDS
// control symbols so the sink never sees a torn frame.
module hdmi_mode_switcher #(
  parameter int NUM_MODES     = 2,
  parameter int NUM_CHANNELS  = 3,
  parameter int DEFAULT_MODE  = 0,
  parameter int STABLE_CYCLES = 16,
  parameter int HOLD_CYCLES   = 64,
  localparam int MW           = $clog2(NUM_MODES)
) (
  input  logic                           clk_pixel,
  input  logic                           reset,
  input  logic [MW-1:0]                  mode_req,
  input  logic [NUM_MODES*NUM_CHANNELS*10-1:0] tmds_in,
  input  logic [NUM_MODES*11-1:0]        cx_in,
  input  logic [NUM_MODES*10-1:0]        cy_in,
  output logic [NUM_CHANNELS*10-1:0]     tmds_out,
  output logic [10:0]                    cx,
  output logic [9:0]                     cy,
  output logic [MW-1:0]                  mode_active,
  output logic                           switching
);

  typedef enum logic [1:0] {S_RUN, S_ARM, S_WAIT, S_BLANK} state_t;

  // Counter widths hold STABLE_CYCLES-1 / HOLD_CYCLES-1 without wrapping.
  localparam int SW   = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int HW   = (HOLD_CYCLES > 1)   ? $clog2(HOLD_CYCLES)   : 1;
  localparam int NSEL = 1 << MW;
  localparam int TW   = NUM_CHANNELS * 10;

  localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_CYCLES - 1);
  localparam logic [MW:0]   NM          = (MW+1)'(NUM_MODES);
  localparam logic [MW-1:0] DEF         = MW'(DEFAULT_MODE);
  localparam logic [9:0]    CTRL        = 10'b1101010100;

  // Per-mode views of the flattened inputs; index values beyond NUM_MODES
  // read as zero so every select index is in range.
  logic [TW-1:0] tmds_arr [NSEL];
  logic [10:0]   cx_arr   [NSEL];
  logic [9:0]    cy_arr   [NSEL];

  for (genvar m = 0; m < NSEL; m++) begin : g_mode
    if (m < NUM_MODES) begin : g_real
      assign tmds_arr[m] = tmds_in[m*TW +: TW];
      assign cx_arr[m]   = cx_in[m*11 +: 11];
      assign cy_arr[m]   = cy_in[m*10 +: 10];
    end else begin : g_unused
      assign tmds_arr[m] = '0;
      assign cx_arr[m]   = '0;
      assign cy_arr[m]   = '0;
    end
  end

  state_t        state_q, state_d;
  logic [MW-1:0] mode_q, mode_d;
  logic [MW-1:0] pend_q, pend_d;
  logic [SW-1:0] scnt_q, scnt_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [TW-1:0] tmds_q, tmds_d;
  logic [10:0]   cx_q, cx_d;
  logic [9:0]    cy_q, cy_d;
  logic          sw_q, sw_d;

  logic          req_ok;
  logic [MW-1:0] req_eff;
  logic          origin;

  // An out-of-range request behaves as if it asked for the current mode.
  assign req_ok  = {1'b0, mode_req} < NM;
  assign req_eff = req_ok ? mode_req : mode_q;
  assign origin  = (cx_arr[mode_q] == 11'd0) && (cy_arr[mode_q] == 10'd0);

  // Next-state logic: debounce, wait for frame origin, then blank.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    pend_d  = pend_q;
    scnt_d  = scnt_q;
    hcnt_d  = hcnt_q;
    case (state_q)
      S_RUN: begin
        if (req_eff != mode_q) begin
          pend_d  = req_eff;
          scnt_d  = '0;
          state_d = S_ARM;
        end
      end
      S_ARM: begin
        if (req_eff == mode_q) begin
          state_d = S_RUN;
        end else if (req_eff != pend_q) begin
          pend_d = req_eff;
          scnt_d = '0;
        end else if (scnt_q == STABLE_LAST) begin
          state_d = S_WAIT;
        end else begin
          scnt_d = scnt_q + SW'(1);
        end
      end
      S_WAIT: begin
        // Frame origin wins over a simultaneous abort; pending stays latched.
        if (origin) begin
          mode_d  = pend_q;
          hcnt_d  = '0;
          state_d = S_BLANK;
        end else if (req_eff == mode_q) begin
          state_d = S_RUN;
        end
      end
      S_BLANK: begin
        if (hcnt_q == HOLD_LAST) begin
          state_d = S_RUN;
        end else begin
          hcnt_d = hcnt_q + HW'(1);
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  // Output datapath follows the mode selected after this cycle's update.
  always_comb begin
    tmds_d = (state_d == S_BLANK) ? {NUM_CHANNELS{CTRL}} : tmds_arr[mode_d];
    cx_d   = cx_arr[mode_d];
    cy_d   = cy_arr[mode_d];
    sw_d   = (state_d != S_RUN);
  end

  // State and registered outputs; reset aborts any switch in progress.
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      state_q <= S_RUN;
      mode_q  <= DEF;
      pend_q  <= DEF;
      scnt_q  <= '0;
      hcnt_q  <= '0;
      tmds_q  <= {NUM_CHANNELS{CTRL}};
      cx_q    <= '0;
      cy_q    <= '0;
      sw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      pend_q  <= pend_d;
      scnt_q  <= scnt_d;
      hcnt_q  <= hcnt_d;
      tmds_q  <= tmds_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      sw_q    <= sw_d;
    end
  end

  assign tmds_out    = tmds_q;
  assign cx          = cx_q;
  assign cy          = cy_q;
  assign mode_active = mode_q;
  assign switching   = sw_q;

endmodule

// File: tb/tb_hdmi_mode_switcher.sv
// Bench for hdmi_mode_switcher: three modes (so index 3 is invalid), default
// mode 1. Directed request sequences plus random ones, every cycle compared
// against a behavioural model of the switching rules.
module tb_hdmi_mode_switcher;
  localparam int NM  = 3;
  localparam int NC  = 3;
  localparam int DEF = 1;
  localparam int STB = 16;
  localparam int HLD = 64;
  localparam int MW  = 2;
  localparam logic [9:0] CTRL = 10'b1101010100;

  logic                   clk_pixel = 1'b0;
  logic                   reset = 1'b0;
  logic [MW-1:0]          mode_req = '0;
  logic [NM*NC*10-1:0]    tmds_in = '0;
  logic [NM*11-1:0]       cx_in = '0;
  logic [NM*10-1:0]       cy_in = '0;
  logic [NC*10-1:0]       tmds_out;
  logic [10:0]            cx;
  logic [9:0]             cy;
  logic [MW-1:0]          mode_active;
  logic                   switching;

  hdmi_mode_switcher #(
    .NUM_MODES(NM), .NUM_CHANNELS(NC), .DEFAULT_MODE(DEF),
    .STABLE_CYCLES(STB), .HOLD_CYCLES(HLD)
  ) dut (
    .clk_pixel(clk_pixel), .reset(reset), .mode_req(mode_req),
    .tmds_in(tmds_in), .cx_in(cx_in), .cy_in(cy_in),
    .tmds_out(tmds_out), .cx(cx), .cy(cy),
    .mode_active(mode_active), .switching(switching)
  );

  always #5 clk_pixel = ~clk_pixel;

  int total = 0;
  int bad   = 0;

  // Per-mode timing generators with distinct small frame sizes.
  int tm_cx [NM];
  int tm_cy [NM];

  // Model: act = mode on air, cand = requested target (-1 none),
  // held = cycles cand has been seen, armed = debounced and waiting for
  // the frame origin, in_blank/blank_left = control-period bookkeeping.
  int act, cand, held, blank_left;
  bit armed, in_blank;
  logic [NC*10-1:0] e_tmds;
  int e_cx, e_cy;
  bit e_sw;

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void mdl_reset();
    act = DEF; cand = -1; held = 0; armed = 0; in_blank = 0; blank_left = 0;
    e_tmds = {NC{CTRL}}; e_cx = 0; e_cy = 0; e_sw = 0;
  endfunction

  // One pixel-clock edge of the switching rules, using the inputs now driven.
  function automatic void mdl_tick();
    int eff;
    eff = (int'(mode_req) < NM) ? int'(mode_req) : act;
    if (in_blank) begin
      if (blank_left > 0) blank_left--;
      else in_blank = 0;
    end else if (armed) begin
      if (tm_cx[act] == 0 && tm_cy[act] == 0) begin
        act = cand; cand = -1; armed = 0;
        in_blank = 1; blank_left = HLD - 1;
      end else if (eff == act) begin
        armed = 0; cand = -1;
      end
    end else if (cand >= 0) begin
      if (eff == act) cand = -1;
      else if (eff != cand) begin cand = eff; held = 1; end
      else if (held >= STB) armed = 1;
      else held++;
    end else if (eff != act) begin
      cand = eff; held = 1;
    end
    e_tmds = in_blank ? {NC{CTRL}} : tmds_in[act*NC*10 +: NC*10];
    e_cx   = tm_cx[act];
    e_cy   = tm_cy[act];
    e_sw   = in_blank || armed || (cand >= 0);
  endfunction

  task automatic compare_all();
    chk("tmds_out", tmds_out, e_tmds);
    chk("cx", cx, e_cx);
    chk("cy", cy, e_cy);
    chk("mode_active", mode_active, act);
    chk("switching", switching, e_sw);
  endtask

  task automatic drive_inputs();
    for (int m = 0; m < NM; m++) begin
      cx_in[m*11 +: 11] = 11'(tm_cx[m]);
      cy_in[m*10 +: 10] = 10'(tm_cy[m]);
    end
    for (int i = 0; i < NM*NC; i++) tmds_in[i*10 +: 10] = 10'($urandom);
  endtask

  task automatic adv_timing();
    for (int m = 0; m < NM; m++) begin
      tm_cx[m]++;
      if (tm_cx[m] == 24 + 5*m) begin
        tm_cx[m] = 0;
        tm_cy[m]++;
        if (tm_cy[m] == 4 + m) tm_cy[m] = 0;
      end
    end
  endtask

  task automatic step();
    if (reset) mdl_reset();
    else mdl_tick();
    @(posedge clk_pixel);
    #1;
    compare_all();
    adv_timing();
    drive_inputs();
  endtask

  task automatic run(input int req, input int n);
    mode_req = MW'(req);
    repeat (n) step();
  endtask

  initial begin
    bit found;
    for (int m = 0; m < NM; m++) begin tm_cx[m] = 7*m; tm_cy[m] = 0; end
    mode_req = MW'(DEF);
    drive_inputs();
    #2 reset = 1'b1;
    #1 mdl_reset();
    compare_all();
    repeat (3) step();
    reset = 1'b0;
    step();                       // first edge after release: mode 1 data
    run(0, 300);                  // full switch 1 -> 0
    run(1, 5); run(0, 40);        // short glitch, must abort
    run(3, 10);                   // invalid index ignored
    run(1, 10); run(2, 350);      // target changes, switch to 2
    run(0, 20);                   // arm towards 0
    run(1, 500);                  // change during wait: 0 first, then 1
    // Reset in the middle of the control period.
    mode_req = MW'(0);
    found = 0;
    for (int i = 0; i < 600 && !found; i++) begin
      step();
      if (in_blank && (HLD - 1 - blank_left) == 30) found = 1;
    end
    chk("reach_blank_hold30", found, 1);
    #3 reset = 1'b1;
    #1 mdl_reset();
    compare_all();
    repeat (2) step();
    reset = 1'b0;
    run(1, 20);
    // Random request traffic, including the invalid index.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) mode_req = MW'($urandom_range(0, 3));
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hdmi_mode_switcher.md
Name: hdmi_mode_switcher

Overview:
- Generalised successor to the two-standard HDMI output select. Takes NUM_MODES pre-encoded TMDS symbol sets and their cx/cy counters, one per video timing generator, and selects one for the serializer.
- Mode changes are glitch-free: the request is debounced, the switch happens only at the active mode's frame origin, and the output is held in a TMDS control period for a programmable number of cycles before the new mode's data is passed through.
- Sits between the per-mode hdmi_output instances and the serializer, in the pixel clock domain.

Parameters:
- NUM_MODES, 2: number of timing generators/modes (2..8).
- NUM_CHANNELS, 3: TMDS channels per mode.
- DEFAULT_MODE, 0: mode index active after reset.
- STABLE_CYCLES, 16: cycles mode_req must hold a new valid value before a switch is armed (>=1).
- HOLD_CYCLES, 64: cycles of forced control symbols after the switch (>=1).
- MW, $clog2(NUM_MODES): mode index width (derived, not overridable).

Ports:
- clk_pixel  in  1  pixel clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- mode_req  in  MW  requested mode index.
- tmds_in  in  NUM_MODES*NUM_CHANNELS*10  flattened; mode m, channel c at bits [(m*NUM_CHANNELS+c)*10 +: 10].
- cx_in  in  NUM_MODES*11  mode m at [m*11 +: 11].
- cy_in  in  NUM_MODES*10  mode m at [m*10 +: 10].
- tmds_out  out  NUM_CHANNELS*10  selected symbols, channel c at [c*10 +: 10].
- cx  out  11  selected cx.
- cy  out  10  selected cy.
- mode_active  out  MW  currently selected mode.
- switching  out  1  high while in ARM, WAIT_FRAME or BLANK.

Behaviour:
- Reset values: state=RUN, mode_active=DEFAULT_MODE, pending=DEFAULT_MODE, counters=0, tmds_out=all channels 10'b1101010100 (CTRL 00), cx=0, cy=0, switching=0.
- Reset is asynchronous and may arrive in any state. It aborts any switch in progress and restores the reset values immediately.
- Datapath: all outputs are registered, with 1 cycle latency from the inputs. Each cycle: cx <= cx_in[sel], cy <= cy_in[sel], where sel=mode_active after any update made this cycle.
  - tmds_out <= tmds_in[sel] in RUN, ARM and WAIT_FRAME.
  - tmds_out <= CTRL symbol on every channel in BLANK.
- A request is valid when mode_req < NUM_MODES. Invalid requests are treated as equal to mode_active and never start a switch.
- FSM:
  - RUN: if mode_req is valid and != mode_active, then pending<=mode_req, stable_cnt<=0, go to ARM.
  - ARM:
    - If mode_req == mode_active or invalid, go to RUN (abort).
    - Else if mode_req != pending, then pending<=mode_req and stable_cnt<=0 (restart).
    - Else if stable_cnt == STABLE_CYCLES-1, go to WAIT_FRAME.
    - Else stable_cnt++.
  - WAIT_FRAME:
    - Abort to RUN if mode_req == mode_active.
    - Later valid changes of mode_req are ignored: pending is latched.
    - When cx_in[mode_active]==0 and cy_in[mode_active]==0: mode_active<=pending, hold_cnt<=0, go to BLANK.
    - The frame-origin check has priority over the abort in the same cycle.
  - BLANK: hold_cnt++. When hold_cnt == HOLD_CYCLES-1, go to RUN. Requests are ignored here and re-evaluated in RUN.
- switching is a registered output. It is 1 exactly when the next state is ARM, WAIT_FRAME or BLANK.
- The CTRL symbol is output for exactly HOLD_CYCLES consecutive tmds_out cycles per switch, starting the cycle after the frame origin is sampled.
- Counters are sized to hold STABLE_CYCLES-1 and HOLD_CYCLES-1 without wrap.
- With NUM_MODES not a power of two, unused index values are invalid (see valid-request rule).

Test Plan:
- Reset with DEFAULT_MODE=1, NUM_MODES=2 -> tmds_out=CTRL on all channels, cx=cy=0, mode_active=1, switching=0. One cycle after release, tmds_out and cx equal mode 1's inputs.
- mode_req 0->1, stable 16 cycles, mode 0 frame origin reached 100 cycles later -> switching rises the cycle after the request.
  - mode_active changes to 1 on the origin-sampling edge.
  - Exactly 64 CTRL cycles follow, then mode 1 data; switching falls with the first mode 1 data cycle.
- mode_req glitches 0->1 for 5 cycles then back to 0 -> state returns to RUN, mode_active stays 0, tmds_out never shows CTRL.
- NUM_MODES=3: mode_req 0->1 for 10 cycles, then 2 held -> a switch to 2 occurs only after 16 stable cycles of 2. An input of 3 is ignored throughout.
- Reset asserted mid-BLANK (hold_cnt=30) -> outputs immediately return to reset values, mode_active=DEFAULT_MODE, no residual CTRL count after release.
- mode_req changes during WAIT_FRAME to a third mode -> switch completes to the originally latched pending mode, then a new switch starts from RUN.
